// File: rtl/bmc_array_if.sv
// Handshake and metric bus for the branch-metric unit.
// The slave side is the bmc_array itself, the master side is whoever drives
// symbols in and takes metrics out.
interface bmc_array_if #(
  parameter int RATE_N = 2,
  parameter int SOFT_W = 1
);
  localparam int SMAX = (1 << SOFT_W) - 1;
  localparam int MW   = $clog2(RATE_N * SMAX + 1);
  localparam int NCW  = 1 << RATE_N;

  logic                       in_valid;
  logic                       in_ready;
  logic [RATE_N*SOFT_W-1:0]   rx_sym;
  logic [RATE_N-1:0]          erase;
  logic                       out_valid;
  logic                       out_ready;
  logic [NCW*MW-1:0]          bm;
  logic [RATE_N-1:0]          bm_min_idx;
  logic [15:0]                sym_cnt;

  modport master (
    output in_valid, rx_sym, erase, out_ready,
    input  in_ready, out_valid, bm, bm_min_idx, sym_cnt
  );

  modport slave (
    input  in_valid, rx_sym, erase, out_ready,
    output in_ready, out_valid, bm, bm_min_idx, sym_cnt
  );
endinterface

// File: rtl/bmc_array.sv
// Branch-metric unit for the Viterbi decoder.
// Stage 1 holds the per-bit distances for both codeword bit polarities,
// stage 2 holds the summed metric of every candidate codeword and the index
// of the smallest one. Both stages advance together on a single enable, so a
// stalled output freezes the whole pipe and bubbles stay where they are.
module bmc_array #(
  parameter int RATE_N = 2,
  parameter int SOFT_W = 1
) (
  input logic           clk,
  input logic           rst,
  bmc_array_if.slave    bus
);
  localparam int SMAX = (1 << SOFT_W) - 1;
  localparam int MW   = $clog2(RATE_N * SMAX + 1);
  localparam int NCW  = 1 << RATE_N;

  logic                               en;

  // Distance of bit i when the codeword bit is 0 (d0) or 1 (d1).
  logic [RATE_N-1:0][SOFT_W-1:0]      d0_d, d1_d;
  logic [RATE_N-1:0][SOFT_W-1:0]      s1_d0_q, s1_d1_q;
  logic                               s1_valid_q;

  logic [NCW-1:0][MW-1:0]             sum_d;
  logic [MW-1:0]                      min_d;
  logic [RATE_N-1:0]                  idx_d;

  logic [NCW*MW-1:0]                  bm_q;
  logic [RATE_N-1:0]                  idx_q;
  logic                               s2_valid_q;
  logic [15:0]                        cnt_q;

  assign en            = !s2_valid_q || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = s2_valid_q;
  assign bus.bm        = bm_q;
  assign bus.bm_min_idx = idx_q;
  assign bus.sym_cnt   = cnt_q;

  // Per-bit distances with puncturing applied; SMAX - rx is ~rx because SMAX is all ones.
  always_comb begin
    d0_d = '0;
    d1_d = '0;
    for (int i = 0; i < RATE_N; i++) begin
      if (!bus.erase[i]) begin
        d0_d[i] = bus.rx_sym[i*SOFT_W +: SOFT_W];
        d1_d[i] = ~bus.rx_sym[i*SOFT_W +: SOFT_W];
      end
    end
  end

  // Codeword metrics from the stage-1 distances and the first minimum in ascending order.
  always_comb begin
    sum_d = '0;
    for (int c = 0; c < NCW; c++) begin
      for (int i = 0; i < RATE_N; i++) begin
        if (((c >> i) & 1) != 0) begin
          sum_d[c] = sum_d[c] + MW'(s1_d1_q[i]);
        end else begin
          sum_d[c] = sum_d[c] + MW'(s1_d0_q[i]);
        end
      end
    end
    min_d = sum_d[0];
    idx_d = '0;
    for (int c = 1; c < NCW; c++) begin
      if (sum_d[c] < min_d) begin
        min_d = sum_d[c];
        idx_d = RATE_N'(c);
      end
    end
  end

  // Pipeline registers; data only loads alongside a valid so bubbles never pull in undriven inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_d0_q    <= '0;
      s1_d1_q    <= '0;
      s2_valid_q <= 1'b0;
      bm_q       <= '0;
      idx_q      <= '0;
    end else if (en) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_d0_q <= d0_d;
        s1_d1_q <= d1_d;
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        bm_q  <= sum_d;
        idx_q <= idx_d;
      end
    end
  end

  // Completed output transfers, free-running modulo 2**16.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (s2_valid_q && bus.out_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_bmc_array.sv
// Directed and randomised checks of the branch-metric unit across several
// RATE_N / SOFT_W configurations.
module tb_bmc_array;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_rnd = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bmc_array_if #(.RATE_N(2), .SOFT_W(1)) b0 ();
  bmc_array #(.RATE_N(2), .SOFT_W(1)) u_hard (.clk(clk), .rst(rst), .bus(b0));

  bmc_array_if #(.RATE_N(2), .SOFT_W(3)) b1 ();
  bmc_array #(.RATE_N(2), .SOFT_W(3)) u_soft (.clk(clk), .rst(rst), .bus(b1));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_bm(int rn, int sw, logic [31:0] rx, logic [31:0] er, int c);
    int s;
    int smax;
    int v;
    s = 0;
    smax = (1 << sw) - 1;
    for (int i = 0; i < rn; i++) begin
      if (!er[i]) begin
        v = int'((rx >> (i * sw)) & smax);
        s += (((c >> i) & 1) != 0) ? (smax - v) : v;
      end
    end
    return s;
  endfunction

  // Random streams on other configurations, checked against ref_bm.
  for (genvar g = 0; g < 3; g++) begin : g_rnd
    localparam int RN  = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int SW  = (g == 1) ? 1 : 4;
    localparam int SM  = (1 << SW) - 1;
    localparam int MWG = $clog2(RN * SM + 1);
    localparam int NC  = 1 << RN;

    bmc_array_if #(.RATE_N(RN), .SOFT_W(SW)) bus ();
    bmc_array #(.RATE_N(RN), .SOFT_W(SW)) dut (.clk(clk), .rst(rst_rnd), .bus(bus));

    bit done = 1'b0;
    logic [RN*SW-1:0] q_rx [$];
    logic [RN-1:0]    q_er [$];

    initial begin
      int got;
      int e;
      int exp_min;
      int exp_idx;
      logic [RN*SW-1:0] erx;
      logic [RN-1:0]    eer;
      logic [31:0]      r1;
      logic [31:0]      r2;
      got = 0;
      bus.in_valid  = 1'b0;
      bus.rx_sym    = '0;
      bus.erase     = '0;
      bus.out_ready = 1'b1;
      wait (rst_rnd == 1'b0);
      for (int n = 0; n < 46; n++) begin
        @(negedge clk);
        if (bus.out_valid) begin
          if (q_rx.size() == 0) begin
            check($sformatf("rnd%0d_extra", g), 1, 0);
          end else begin
            erx = q_rx.pop_front();
            eer = q_er.pop_front();
            exp_min = 1 << 30;
            exp_idx = 0;
            for (int c = 0; c < NC; c++) begin
              e = ref_bm(RN, SW, 32'(erx), 32'(eer), c);
              check($sformatf("rnd%0d_bm%0d", g, c), 64'(bus.bm[c*MWG +: MWG]), 64'(e));
              if (e < exp_min) begin
                exp_min = e;
                exp_idx = c;
              end
            end
            check($sformatf("rnd%0d_idx", g), 64'(bus.bm_min_idx), 64'(exp_idx));
            got++;
          end
        end
        if (n < 40) begin
          r1 = $urandom;
          r2 = $urandom;
          bus.in_valid = 1'b1;
          bus.rx_sym   = r1[RN*SW-1:0];
          bus.erase    = (r2[7:5] == 3'd0) ? r2[RN-1:0] : '0;
          q_rx.push_back(bus.rx_sym);
          q_er.push_back(bus.erase);
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      check($sformatf("rnd%0d_count", g), 64'(got), 64'd40);
      done = 1'b1;
    end
  end

  task automatic run_one(input string tag, input logic [1:0] rx, input logic [1:0] er,
                         input logic [7:0] ebm, input logic [1:0] eidx);
    @(negedge clk);
    b0.in_valid = 1'b1;
    b0.rx_sym   = rx;
    b0.erase    = er;
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.erase    = 2'b00;
    @(negedge clk);
    check({tag, "_valid"}, 64'(b0.out_valid), 64'd1);
    check({tag, "_bm"}, 64'(b0.bm), 64'(ebm));
    check({tag, "_idx"}, 64'(b0.bm_min_idx), 64'(eidx));
  endtask

  // Backpressure vectors: {rx, erase} and hand-computed {bm3,bm2,bm1,bm0}, min index.
  logic [1:0] bp_rx  [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
  logic [1:0] bp_er  [6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
  logic [7:0] bp_bm  [6] = '{8'h94, 8'h61, 8'h49, 8'h16, 8'h11, 8'h05};
  logic [1:0] bp_idx [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};

  initial begin
    int k;
    int m;
    int seen;
    int n;
    logic [7:0] held;
    b0.in_valid = 1'b0; b0.rx_sym = '0; b0.erase = '0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.rx_sym = '0; b1.erase = '0; b1.out_ready = 1'b1;
    held = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(b0.out_valid), 64'd0);
    check("rst_bm", 64'(b0.bm), 64'd0);
    check("rst_idx", 64'(b0.bm_min_idx), 64'd0);
    check("rst_sym_cnt", 64'(b0.sym_cnt), 64'd0);
    check("rst_in_ready", 64'(b0.in_ready), 64'd1);
    rst = 1'b0;
    rst_rnd = 1'b0;

    // Hard rx=10 and soft rx bit0=2, bit1=6, presented together.
    b0.in_valid = 1'b1; b0.rx_sym = 2'b10;
    b1.in_valid = 1'b1; b1.rx_sym = {3'd6, 3'd2};
    @(negedge clk);
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
    check("lat_valid_early", 64'(b0.out_valid), 64'd0);
    @(negedge clk);
    check("hard_valid", 64'(b0.out_valid), 64'd1);
    check("hard_bm", 64'(b0.bm), 64'h49);
    check("hard_idx", 64'(b0.bm_min_idx), 64'd2);
    check("soft_valid", 64'(b1.out_valid), 64'd1);
    check("soft_bm", 64'(b1.bm), 64'h63B8);
    check("soft_idx", 64'(b1.bm_min_idx), 64'd2);
    @(negedge clk);
    check("hard_valid_drop", 64'(b0.out_valid), 64'd0);
    check("hard_sym_cnt", 64'(b0.sym_cnt), 64'd1);

    run_one("erase1", 2'b10, 2'b10, 8'h44, 2'd0);
    run_one("erase_all", 2'b11, 2'b11, 8'h00, 2'd0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Stream 6 symbols with a 5-cycle output stall.
    k = 0;
    m = 0;
    for (int cyc = 0; cyc < 40 && m < 6; cyc++) begin
      @(negedge clk);
      b0.out_ready = !(cyc >= 3 && cyc < 8);
      if (k < 6) begin
        b0.in_valid = 1'b1;
        b0.rx_sym   = bp_rx[k];
        b0.erase    = bp_er[k];
      end else begin
        b0.in_valid = 1'b0;
      end
      #1;
      if (!b0.out_ready) begin
        check("bp_in_ready", 64'(b0.in_ready), 64'd0);
        check("bp_valid_held", 64'(b0.out_valid), 64'd1);
        if (cyc == 3) held = b0.bm;
        else check("bp_bm_held", 64'(b0.bm), 64'(held));
      end
      if (b0.in_valid && b0.in_ready) k++;
      if (b0.out_valid && b0.out_ready) begin
        check($sformatf("bp_bm%0d", m), 64'(b0.bm), 64'(bp_bm[m]));
        check($sformatf("bp_idx%0d", m), 64'(b0.bm_min_idx), 64'(bp_idx[m]));
        m++;
      end
    end
    check("bp_delivered", 64'(m), 64'd6);
    @(negedge clk);
    b0.in_valid = 1'b0;
    b0.erase = 2'b00;
    b0.out_ready = 1'b1;
    check("bp_sym_cnt", 64'(b0.sym_cnt), 64'd6);

    // Two symbols in flight when reset hits.
    @(negedge clk);
    b0.in_valid = 1'b1; b0.rx_sym = 2'b01;
    @(negedge clk);
    b0.rx_sym = 2'b11;
    @(negedge clk);
    b0.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", 64'(b0.out_valid), 64'd0);
    check("mid_rst_sym_cnt", 64'(b0.sym_cnt), 64'd0);
    check("mid_rst_bm", 64'(b0.bm), 64'd0);
    check("mid_rst_idx", 64'(b0.bm_min_idx), 64'd0);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b0.out_valid) seen++;
    end
    check("mid_rst_no_emit", 64'(seen), 64'd0);

    // 65537 back-to-back transfers wrap the counter to 1.
    b0.in_valid = 1'b1;
    b0.rx_sym = 2'b00;
    n = 0;
    for (int cyc = 0; cyc < 70000 && n < 65537; cyc++) begin
      @(negedge clk);
      if (b0.out_valid) begin
        n++;
        if (n == 65536) check("wrap_ffff", 64'(b0.sym_cnt), 64'hFFFF);
      end
    end
    check("wrap_transfers", 64'(n), 64'd65537);
    @(posedge clk);
    #1;
    b0.in_valid = 1'b0;
    b0.out_ready = 1'b0;
    @(negedge clk);
    check("wrap_sym_cnt", 64'(b0.sym_cnt), 64'd1);

    for (int t = 0; t < 1000 && !(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done); t++) begin
      @(negedge clk);
    end
    check("rnd0_done", 64'(g_rnd[0].done), 64'd1);
    check("rnd1_done", 64'(g_rnd[1].done), 64'd1);
    check("rnd2_done", 64'(g_rnd[2].done), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
